// File: rtl/sr_to_t_decoder_if.sv
// Handshake and status bundle for the SR-to-T decoder.
// master: command source / downstream sink side; slave: the decoder itself.
interface sr_to_t_decoder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_set;
  logic [WIDTH-1:0] s_rst;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_toggle;
  logic [WIDTH-1:0] m_state;
  logic [WIDTH-1:0] m_illegal;
  logic             clr_err;
  logic             err_sticky;
  logic [CNT_W-1:0] illegal_cnt;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output s_valid, s_set, s_rst, m_ready, clr_err,
    input  s_ready, m_valid, m_toggle, m_state, m_illegal, err_sticky, illegal_cnt, toggle_cnt
  );

  modport slave (
    input  s_valid, s_set, s_rst, m_ready, clr_err,
    output s_ready, m_valid, m_toggle, m_state, m_illegal, err_sticky, illegal_cnt, toggle_cnt
  );
endinterface

// File: rtl/sr_to_t_decoder.sv
// Rebuilds toggle excitations from per-bit set/reset commands against a shadow
// copy of an SR register bank; flags S=R=1 and keeps saturating event counters.
module sr_to_t_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  sr_to_t_decoder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Shadow state; doubles as the registered m_state output.
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tog_c;
  logic [WIDTH-1:0] ill_c;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   tog_sum;
  logic             accept;
  logic             any_ill;

  // Ready only depends on the output slot, so there is no s_* -> m_* path.
  assign bus.s_ready = ~bus.m_valid | bus.m_ready;
  assign bus.m_state = q;

  // Per-bit decode against the pre-update state, plus popcount for the counter.
  always_comb begin
    ill_c   = bus.s_set & bus.s_rst;
    tog_c   = (bus.s_set & ~bus.s_rst & ~q) | (bus.s_rst & ~bus.s_set & q);
    pop     = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + {{CNT_W{1'b0}}, tog_c[i]};
    end
    tog_sum = {1'b0, bus.toggle_cnt} + pop;
    any_ill = |ill_c;
    accept  = bus.s_valid & bus.s_ready;
  end

  // Output slot, shadow state and counters; all advance only on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q               <= '0;
      bus.m_valid     <= 1'b0;
      bus.m_toggle    <= '0;
      bus.m_illegal   <= '0;
      bus.err_sticky  <= 1'b0;
      bus.illegal_cnt <= '0;
      bus.toggle_cnt  <= '0;
    end else begin
      if (accept) begin
        q              <= q ^ tog_c;
        bus.m_valid    <= 1'b1;
        bus.m_toggle   <= tog_c;
        bus.m_illegal  <= ill_c;
        bus.toggle_cnt <= tog_sum[CNT_W] ? CntMax : tog_sum[CNT_W-1:0];
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      // A fresh illegal event beats a simultaneous clear.
      if (accept && any_ill) begin
        bus.err_sticky <= 1'b1;
        if (bus.clr_err) begin
          bus.illegal_cnt <= CNT_W'(1);
        end else if (bus.illegal_cnt != CntMax) begin
          bus.illegal_cnt <= bus.illegal_cnt + CNT_W'(1);
        end
      end else if (bus.clr_err) begin
        bus.err_sticky  <= 1'b0;
        bus.illegal_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sr_to_t_decoder.sv
// Bench for sr_to_t_decoder: directed scenarios plus a randomized run against
// a behavioural model of the SR bank and its counters.
module tb_sr_to_t_decoder;

  localparam int unsigned W = 4;
  localparam int unsigned CW = 5;
  localparam int CMAX = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_to_t_decoder_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sr_to_t_decoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  logic [W-1:0] exp_q, exp_tog, exp_ill;
  logic         exp_mv, exp_err;
  int           exp_icnt, exp_tcnt;

  task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] r,
                       input logic mr, input logic clr);
    bus.s_valid = v;
    bus.s_set   = s;
    bus.s_rst   = r;
    bus.m_ready = mr;
    bus.clr_err = clr;
  endtask

  // Advance one clock and update the model from the values driven for that edge.
  task automatic tick();
    logic         acc, rs, mr, clr;
    logic [W-1:0] s, r, tog, ill;
    rs  = rst;
    mr  = bus.m_ready;
    clr = bus.clr_err;
    s   = bus.s_set;
    r   = bus.s_rst;
    acc = bus.s_valid && (!exp_mv || mr);
    @(posedge clk);
    #1;
    if (!rs) begin
      exp_q = '0; exp_tog = '0; exp_ill = '0; exp_mv = 1'b0; exp_err = 1'b0;
      exp_icnt = 0; exp_tcnt = 0;
    end else if (acc) begin
      tog = '0;
      ill = '0;
      for (int i = 0; i < int'(W); i++) begin
        if (s[i] && r[i]) ill[i] = 1'b1;
        else if (s[i]) begin tog[i] = !exp_q[i]; exp_q[i] = 1'b1; end
        else if (r[i]) begin tog[i] = exp_q[i];  exp_q[i] = 1'b0; end
      end
      exp_tog  = tog;
      exp_ill  = ill;
      exp_mv   = 1'b1;
      exp_tcnt = exp_tcnt + $countones(tog);
      if (exp_tcnt > CMAX) exp_tcnt = CMAX;
      if (ill != 0) begin
        exp_err  = 1'b1;
        exp_icnt = clr ? 1 : ((exp_icnt < CMAX) ? exp_icnt + 1 : CMAX);
      end else if (clr) begin
        exp_err = 1'b0; exp_icnt = 0;
      end
    end else begin
      if (mr) exp_mv = 1'b0;
      if (clr) begin exp_err = 1'b0; exp_icnt = 0; end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.m_valid, bus.m_state, bus.m_toggle, bus.m_illegal, bus.err_sticky,
         bus.illegal_cnt, bus.toggle_cnt, bus.s_ready} !== {1'b0, 4'b0, 4'b0, 4'b0, 1'b0,
         5'd0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got mv=%b st=%b tg=%b il=%b err=%b ic=%0d tc=%0d rdy=%b",
               bus.m_valid, bus.m_state, bus.m_toggle, bus.m_illegal, bus.err_sticky,
               bus.illegal_cnt, bus.toggle_cnt, bus.s_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_valid, bus.m_toggle, bus.m_state} !== {1'b1, 4'b0101, 4'b0101}) begin
      failures++;
      $display("FAIL basic_set got mv=%b tg=%b st=%b exp mv=1 tg=0101 st=0101",
               bus.m_valid, bus.m_toggle, bus.m_state);
    end
    drive(1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_toggle, bus.m_state, bus.toggle_cnt} !== {4'b0001, 4'b0100, 5'd3}) begin
      failures++;
      $display("FAIL basic_reset got tg=%b st=%b tc=%0d exp tg=0001 st=0100 tc=3",
               bus.m_toggle, bus.m_state, bus.toggle_cnt);
    end
  endtask

  task automatic test_redundant();
    drive(1'b1, 4'b0100, 4'b1000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_toggle, bus.m_state, bus.toggle_cnt} !== {4'b0000, 4'b0100, 5'd3}) begin
      failures++;
      $display("FAIL redundant got tg=%b st=%b tc=%0d exp tg=0000 st=0100 tc=3",
               bus.m_toggle, bus.m_state, bus.toggle_cnt);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'b1001, 4'b1000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_illegal, bus.m_toggle, bus.m_state, bus.err_sticky, bus.illegal_cnt} !==
        {4'b1000, 4'b0001, 4'b0101, 1'b1, 5'd1}) begin
      failures++;
      $display("FAIL illegal_beat got il=%b tg=%b st=%b err=%b ic=%0d exp 1000 0001 0101 1 1",
               bus.m_illegal, bus.m_toggle, bus.m_state, bus.err_sticky, bus.illegal_cnt);
    end
    drive(1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1);
    tick();
    checks++;
    if ({bus.m_illegal, bus.err_sticky, bus.illegal_cnt} !== {4'b0010, 1'b1, 5'd1}) begin
      failures++;
      $display("FAIL clr_with_illegal got il=%b err=%b ic=%0d exp il=0010 err=1 ic=1",
               bus.m_illegal, bus.err_sticky, bus.illegal_cnt);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    checks++;
    if ({bus.err_sticky, bus.illegal_cnt, bus.toggle_cnt, bus.m_valid} !==
        {1'b0, 5'd0, 5'd4, 1'b0}) begin
      failures++;
      $display("FAIL clr_only got err=%b ic=%0d tc=%0d mv=%b exp err=0 ic=0 tc=4 mv=0",
               bus.err_sticky, bus.illegal_cnt, bus.toggle_cnt, bus.m_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.m_valid, bus.m_toggle, bus.m_state, bus.toggle_cnt} !==
        {1'b1, 4'b1000, 4'b1101, 5'd5}) begin
      failures++;
      $display("FAIL stall_first got mv=%b tg=%b st=%b tc=%0d exp mv=1 tg=1000 st=1101 tc=5",
               bus.m_valid, bus.m_toggle, bus.m_state, bus.toggle_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.s_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready cycle=%0d got=%b exp=0", k, bus.s_ready);
      end
      tick();
      checks++;
      if ({bus.m_valid, bus.m_toggle, bus.m_state, bus.m_illegal, bus.toggle_cnt,
           bus.illegal_cnt} !== {1'b1, 4'b1000, 4'b1101, 4'b0000, 5'd5, 5'd0}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got mv=%b tg=%b st=%b il=%b tc=%0d ic=%0d",
                 k, bus.m_valid, bus.m_toggle, bus.m_state, bus.m_illegal,
                 bus.toggle_cnt, bus.illegal_cnt);
      end
    end
    drive(1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b exp=1", bus.s_ready);
    end
    tick();
    drive(1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_valid, bus.m_toggle, bus.m_state, bus.toggle_cnt} !==
        {1'b1, exp_tog, exp_q, 5'(exp_tcnt)} || exp_q !== 4'b0100) begin
      failures++;
      $display("FAIL release_stream got mv=%b tg=%b st=%b tc=%0d exp mv=1 tg=%b st=%b tc=%0d",
               bus.m_valid, bus.m_toggle, bus.m_state, bus.toggle_cnt, exp_tog, exp_q,
               exp_tcnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, (k % 2 == 0) ? 4'b1111 : 4'b0000, (k % 2 == 0) ? 4'b0000 : 4'b1111,
            1'b1, 1'b0);
      tick();
    end
    checks++;
    if (bus.toggle_cnt !== 5'd31) begin
      failures++;
      $display("FAIL saturate got tc=%0d exp=31", bus.toggle_cnt);
    end
    drive(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.toggle_cnt, bus.m_toggle} !== {5'd31, 4'b1111}) begin
      failures++;
      $display("FAIL saturate_hold got tc=%0d tg=%b exp tc=31 tg=1111",
               bus.toggle_cnt, bus.m_toggle);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 4'b0110, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.m_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stall got mv=%b exp=1", bus.m_valid);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.m_valid, bus.m_state, bus.toggle_cnt, bus.illegal_cnt, bus.err_sticky,
         bus.s_ready} !== {1'b0, 4'b0000, 5'd0, 5'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_stall_reset got mv=%b st=%b tc=%0d ic=%0d err=%b rdy=%b",
               bus.m_valid, bus.m_state, bus.toggle_cnt, bus.illegal_cnt, bus.err_sticky,
               bus.s_ready);
    end
    drive(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0);
    tick();
    checks++;
    if ({bus.m_valid, bus.m_toggle} !== {1'b1, 4'b0001}) begin
      failures++;
      $display("FAIL post_reset_beat got mv=%b tg=%b exp mv=1 tg=0001",
               bus.m_valid, bus.m_toggle);
    end
  endtask

  task automatic test_random();
    logic mr;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      mr = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), mr,
            $urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (bus.s_ready !== (!exp_mv || mr)) begin
        failures++;
        $display("FAIL rand_ready iter=%0d got=%b exp=%b", k, bus.s_ready, !exp_mv || mr);
      end
      tick();
      checks++;
      if ({bus.m_valid, bus.m_toggle, bus.m_state, bus.m_illegal, bus.err_sticky} !==
          {exp_mv, exp_tog, exp_q, exp_ill, exp_err} ||
          int'(bus.illegal_cnt) != exp_icnt || int'(bus.toggle_cnt) != exp_tcnt) begin
        failures++;
        $display("FAIL rand_out iter=%0d got mv=%b tg=%b st=%b il=%b err=%b ic=%0d tc=%0d exp mv=%b tg=%b st=%b il=%b err=%b ic=%0d tc=%0d",
                 k, bus.m_valid, bus.m_toggle, bus.m_state, bus.m_illegal, bus.err_sticky,
                 bus.illegal_cnt, bus.toggle_cnt, exp_mv, exp_tog, exp_q, exp_ill, exp_err,
                 exp_icnt, exp_tcnt);
      end
    end
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    test_reset();
    test_basic();
    test_redundant();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_to_t_decoder.md
# sr_to_t_decoder

Converts a stream of per-bit set/reset commands back into toggle excitations, the inverse of the T-to-SR excitation encoding used elsewhere in our flip-flop blocks. It keeps a shadow copy of the state of a WIDTH-bit SR register bank. For every accepted command beat it emits the toggle vector that produces the same next state. It also flags illegal S=R=1 commands and keeps saturating event counters. It sits between an SR command source and a T-register bank or checker, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 4, number of flip-flop bits per beat (1..16)
- CNT_W, 8, width of the saturating counters (≥ 5)
- clk  in  1  clock; all logic updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- s_valid  in  1  command beat valid
- s_ready  out  1  decoder can accept a beat
- s_set  in  WIDTH  per-bit S command
- s_rst  in  WIDTH  per-bit R command
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the output beat
- m_toggle  out  WIDTH  required T excitation per bit
- m_state  out  WIDTH  shadow state after this beat is applied
- m_illegal  out  WIDTH  bits that received S=R=1 in this beat
- clr_err  in  1  one-cycle pulse; clears err_sticky and illegal_cnt
- err_sticky  out  1  set by any illegal bit, held until clr_err or reset
- illegal_cnt  out  CNT_W  count of beats containing at least one illegal bit, saturating
- toggle_cnt  out  CNT_W  total number of toggled bits, saturating

## Operation
- Shadow state q[WIDTH] models the SR bank. The bank's reset is 0, so q resets to 0.
- A beat transfers when s_valid & s_ready. Decoding per bit i, using q before the update:
  - SR=00: T=0, q holds.
  - SR=10: T=~q[i], q[i] becomes 1.
  - SR=01: T=q[i], q[i] becomes 0.
  - SR=11: illegal. T=0, q holds (never X), m_illegal[i]=1.
- Output register is one entry deep.
- s_ready = ~m_valid | m_ready, so the block gives full throughput with no bubble when m_ready stays high.
- While stalled (m_valid & ~m_ready):
  - s_set and s_rst are ignored.
  - q does not change.
  - m_* outputs hold stable.
- Counters update only on accepted beats.
  - toggle_cnt: add popcount(T) in CNT_W+1 bits, then clamp at 2^CNT_W−1.
  - illegal_cnt: add 1 if any m_illegal bit is set; clamp at all-ones.
  - err_sticky: set when any m_illegal bit is set.
- clr_err in the same cycle as an accepted illegal beat: the new event wins, giving err_sticky=1 and illegal_cnt=1. clr_err does not clear toggle_cnt.
- Reset (rst=0), including in the middle of a stall, forces:
  - q, m_valid, m_toggle, m_state, m_illegal = 0
  - err_sticky = 0, illegal_cnt = 0, toggle_cnt = 0
  - s_ready = 1 on the first cycle after reset is released.
  - A pending output beat is dropped.

## Timing
- Latency: a beat accepted at edge N appears with m_valid=1 immediately after edge N.
  - m_state equals q after edge N.
  - Counters and err_sticky reflect that beat after edge N.
- The output beat retires at the first edge where m_valid & m_ready. If no new beat is accepted at that edge, m_valid falls.
- s_ready is combinational from m_valid and m_ready. There is no combinational path from s_* to m_*.
- All outputs are registered except s_ready.

## Test plan
- Reset then basic decode (WIDTH=4, m_ready=1):
  - Send S=0101, R=0000 -> m_toggle=0101, m_state=0101.
  - Then S=0000, R=0001 -> m_toggle=0001, m_state=0100; toggle_cnt=3.
- Redundant commands: from state 0100, send S=0100, R=1000 -> m_toggle=0000, m_state=0100, toggle_cnt unchanged.
- Illegal beat:
  - S=1001, R=1000 -> m_illegal=1000, m_toggle=0001 (q[3]=0 holds, bit0 sets), err_sticky=1, illegal_cnt=1.
  - Same cycle pulse: clr_err together with another illegal beat -> err_sticky=1, illegal_cnt=1.
- Backpressure: hold m_ready=0 for 3 cycles with s_valid=1 and changing data.
  - s_ready=0, and m_* hold the first beat.
  - No q or counter change until m_ready=1; then one beat per cycle.
- Saturation (CNT_W=5): 9 beats of S=1111 alternating with R=1111 (36 toggles) -> toggle_cnt=31 and stays there.
- Reset mid-stall: m_valid=1, m_ready=0, rst=0 for one cycle.
  - m_valid=0, all counters 0, m_state=0, s_ready=1.
  - The next beat S=0001 yields m_toggle=0001.
